// File: rtl/nios_mult_pkg.sv
// Shared types and sizing helpers for the sequential multiply unit.
// Optional feature macro consumed by users of this package: NIOS_MULT_SKIP_HIGH_EN.
package nios_mult_pkg;

   typedef enum logic [1:0] {
      MULT_OP_MUL = 2'd0,
      MULT_OP_XUU = 2'd1,
      MULT_OP_XSU = 2'd2,
      MULT_OP_XSS = 2'd3
   } mult_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      CORR = 2'd2,
      DONE = 2'd3
   } mult_state_t;

   function automatic int num_parts(input int width, input int part_w);
      return width / part_w;
   endfunction

   function automatic int full_latency(input int n);
      return n * n + 2;
   endfunction

   function automatic int skip_latency(input int n);
      return (n * (n + 1)) / 2 + 2;
   endfunction

endpackage

// File: rtl/nios_mult_pp.sv
// Unregistered PART_W x PART_W unsigned partial-product slice; one DSP block,
// swappable per device family.
module nios_mult_pp #(
   parameter int PART_W = 16
) (
   input  logic [PART_W-1:0]   a,
   input  logic [PART_W-1:0]   b,
   output logic [2*PART_W-1:0] p
);

   assign p = {{PART_W{1'b0}}, a} * {{PART_W{1'b0}}, b};

endmodule

// File: rtl/nios_design_cpu_mult_seq.sv
// Sequential WIDTH x WIDTH multiplier built on one shared PART_W slice.
// NIOS_MULT_SKIP_HIGH_EN: MUL only visits partial products that reach the low word.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// MULT  | one partial product accumulated per cycle
// CORR  | signed correction of the high word, result registered
// DONE  | out_valid high until out_ready
module nios_design_cpu_mult_seq
   import nios_mult_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int PART_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [WIDTH-1:0] in_src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             busy
);

   localparam int N  = num_parts(WIDTH, PART_W);
   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam int AW = 2 * WIDTH;
   localparam logic [CW-1:0] N_M1 = CW'(N - 1);

   generate
      if ((WIDTH % PART_W) != 0 || N < 2) begin : g_bad_params
         $fatal(1, "nios_design_cpu_mult_seq: WIDTH must be a multiple of PART_W with WIDTH/PART_W >= 2");
      end
   endgenerate

   mult_state_t      state_q, state_d;
   mult_op_t         op_q;
   logic [WIDTH-1:0] src1_q, src2_q;
   logic [AW-1:0]    acc_q;
   logic [CW-1:0]    i_q, j_q;
   logic [WIDTH-1:0] result_q;

   logic [PART_W-1:0]   a_sl, b_sl;
   logic [2*PART_W-1:0] pp;
   logic [AW-1:0]       pp_sh;
   logic [AW-1:0]       acc_corr;
   logic [CW-1:0]       j_last;
   logic                last_pp;
   logic                corr_a, corr_b;

   assign a_sl = src1_q[i_q*PART_W +: PART_W];
   assign b_sl = src2_q[j_q*PART_W +: PART_W];

   nios_mult_pp #(.PART_W(PART_W)) u_pp (
      .a (a_sl),
      .b (b_sl),
      .p (pp)
   );

   assign pp_sh = {{(AW-2*PART_W){1'b0}}, pp} << (PART_W * (32'(i_q) + 32'(j_q)));

   // For MUL the low word only sees pairs with i+j < N, so each row can end early.
   always_comb begin
`ifdef NIOS_MULT_SKIP_HIGH_EN
      j_last = (op_q == MULT_OP_MUL) ? (N_M1 - i_q) : N_M1;
`else
      j_last = N_M1;
`endif
   end

   assign last_pp = (i_q == N_M1) && (j_q == j_last);

   // Unsigned product minus the sign-weighted operands gives the signed high word.
   assign corr_a   = ((op_q == MULT_OP_XSU) || (op_q == MULT_OP_XSS)) && src1_q[WIDTH-1];
   assign corr_b   = (op_q == MULT_OP_XSS) && src2_q[WIDTH-1];
   assign acc_corr = acc_q
                   - (corr_a ? {src2_q, {WIDTH{1'b0}}} : {AW{1'b0}})
                   - (corr_b ? {src1_q, {WIDTH{1'b0}}} : {AW{1'b0}});

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_d = MULT;
         end
         MULT: if (last_pp) state_d = CORR;
         CORR: state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= MULT_OP_MUL;
         src1_q   <= '0;
         src2_q   <= '0;
         acc_q    <= '0;
         i_q      <= '0;
         j_q      <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (!flush) begin
            case (state_q)
               IDLE: if (in_valid) begin
                  op_q   <= mult_op_t'(in_op);
                  src1_q <= in_src1;
                  src2_q <= in_src2;
                  acc_q  <= '0;
                  i_q    <= '0;
                  j_q    <= '0;
               end
               MULT: begin
                  acc_q <= acc_q + pp_sh;
                  if (j_q == j_last) begin
                     j_q <= '0;
                     i_q <= i_q + 1'b1;
                  end else begin
                     j_q <= j_q + 1'b1;
                  end
               end
               CORR: begin
                  acc_q    <= acc_corr;
                  result_q <= (op_q == MULT_OP_MUL) ? acc_corr[WIDTH-1:0] : acc_corr[AW-1:WIDTH];
               end
               default: ;
            endcase
         end
      end
   end

   assign out_result = result_q;

endmodule
